// File: rtl/twos_to_signmag_seq_pkg.sv
// Shared types and constants for the chunked two's-complement to
// sign-magnitude converter.
package twos_to_signmag_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;
    localparam int MAX_WIDTH = 1024;

    // Most negative value of a w-bit operand, right-aligned in MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
        logic [MAX_WIDTH-1:0] r;
        r        = '0;
        r[w-1]   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/twos_to_signmag_seq_chunk_negate.sv
// One chunk of the copy-through-first-one-then-invert negation rule.
// flip_in/flip_out chain the "first 1 already seen" state across chunks.
module chunk_negate #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk_in,
    input  logic             flip_in,
    input  logic             enable,
    output logic [CHUNK-1:0] chunk_out,
    output logic             flip_out
);

    logic f;

    always_comb begin
        chunk_out = chunk_in;
        f         = flip_in;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_out[i] = (enable & f) ? ~chunk_in[i] : chunk_in[i];
            f            = f | chunk_in[i];
        end
        flip_out = enable & f;
    end

endmodule

// File: rtl/twos_to_signmag_seq.sv
// Multi-cycle two's-complement to sign-magnitude converter, processing
// CHUNK bits per cycle LSB-first to keep the negation ripple short.
module twos_to_signmag_seq
    import twos_to_signmag_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mag,
    output logic             sign,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [MAX_WIDTH-1:0] MN_FULL = most_neg(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = MN_FULL[WIDTH-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             sign_q, sign_d;
    logic             flip_q, flip_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK-1:0] chunk_out;
    logic             flip_out;

    assign chunk_in = work_q[cnt_q*CHUNK +: CHUNK];

    chunk_negate #(
        .CHUNK(CHUNK)
    ) u_neg (
        .chunk_in (chunk_in),
        .flip_in  (flip_q),
        .enable   (sign_q),
        .chunk_out(chunk_out),
        .flip_out (flip_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        sign_d  = sign_q;
        flip_d  = flip_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = in;
                    sign_d  = in[WIDTH-1];
                    flip_d  = 1'b0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[cnt_q*CHUNK +: CHUNK] = chunk_out;
                flip_d = flip_out;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    ovf_d   = sign_q & (work_d == MIN_VAL);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            sign_q  <= 1'b0;
            flip_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            sign_q  <= sign_d;
            flip_q  <= flip_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign mag  = work_q;
    assign sign = sign_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_twos_to_signmag_seq.sv
// Self-checking bench for twos_to_signmag_seq (WIDTH=64, CHUNK=8):
// vector table, hand sequences and random operands against an arithmetic model.
module tb_twos_to_signmag_seq;

    localparam int W = 64;
    localparam int N = 8;
    localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;

    logic         clk;
    logic         clr;
    logic         start;
    logic [W-1:0] in;
    logic         busy;
    logic         done;
    logic [W-1:0] mag;
    logic         sign;
    logic         ovf;

    int errors;
    int checks;

    twos_to_signmag_seq #(
        .WIDTH(W),
        .CHUNK(8)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .start(start),
        .in   (in),
        .busy (busy),
        .done (done),
        .mag  (mag),
        .sign (sign),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] op;
        logic [W-1:0] mag;
        logic         sign;
        logic         ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sign-magnitude from plain arithmetic negation.
    function automatic void model(input logic [W-1:0] v, output logic [W-1:0] m,
                                  output logic s, output logic o);
        s = v[W-1];
        m = s ? W'(0 - v) : v;
        o = s && (m == MINV);
    endfunction

    // Launch one operation and track it to done. glitch>0 pulses start with a
    // different operand before edge E<glitch> while the converter is running.
    task automatic run_op(input logic [W-1:0] v, input int glitch,
                          input logic [W-1:0] gval, output int lat);
        bit busy_bad;
        bit got;
        busy_bad = 0;
        got      = 0;
        lat      = -1;
        @(negedge clk);
        start = 1'b1;
        in    = v;
        @(posedge clk);
        #1;
        chk("busy_after_capture", W'(busy), W'(1));
        chk("done_after_capture", W'(done), W'(0));
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (k == glitch) begin
                start = 1'b1;
                in    = gval;
            end else begin
                start = 1'b0;
                in    = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                lat = k;
            end else if (!busy) begin
                busy_bad = 1;
            end
        end
        start = 1'b0;
        chk("latency", W'(lat), W'(N));
        chk("busy_held_in_run", W'(busy_bad), W'(0));
        chk("busy_low_at_done", W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] em;
        logic         es;
        logic         eo;
        logic [W-1:0] v;
        int           lat;
        int           spurious;

        errors = 0;
        checks = 0;
        start  = 1'b0;
        in     = '0;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'h5, 1'b1, 1'b0};
        tbl[1] = '{64'h0000_0000_0000_1234, 64'h1234, 1'b0, 1'b0};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
        tbl[3] = '{64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b1, 1'b0};
        tbl[4] = '{64'h0, 64'h0, 1'b0, 1'b0};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0};
        tbl[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        tbl[7] = '{64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

        clr = 1'b1;
        #3;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_mag", mag, '0);
        chk("rst_sign", W'(sign), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        repeat (2) @(negedge clk);
        clr = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, 0, '0, lat);
            chk($sformatf("tbl%0d_mag", i), mag, tbl[i].mag);
            chk($sformatf("tbl%0d_sign", i), W'(sign), W'(tbl[i].sign));
            chk($sformatf("tbl%0d_ovf", i), W'(ovf), W'(tbl[i].ovf));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_done_pulse", i), W'(done), W'(0));
            chk($sformatf("tbl%0d_mag_held", i), mag, tbl[i].mag);
        end

        // start during RUN must be ignored
        run_op(64'hFFFF_FFFF_FFFF_FFFB, 3, 64'h0000_0000_0000_1234, lat);
        chk("glitch_mag", mag, 64'h5);
        chk("glitch_sign", W'(sign), W'(1));
        @(posedge clk);
        #1;
        chk("glitch_no_extra", W'(busy), W'(0));

        // back-to-back: second start sampled in the DONE cycle
        run_op(64'hFFFF_FFFF_FFFF_FFFB, 0, '0, lat);
        chk("b2b_first_mag", mag, 64'h5);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 0, '0, lat);
        chk("b2b_second_mag", mag, 64'h1);
        chk("b2b_second_sign", W'(sign), W'(1));
        repeat (2) @(posedge clk);

        // asynchronous clear in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        in    = 64'hFFFF_FFFF_FFFF_FFFB;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_pre_clr", W'(busy), W'(1));
        clr = 1'b1;
        #1;
        chk("clr_busy", W'(busy), W'(0));
        chk("clr_done", W'(done), W'(0));
        chk("clr_mag", mag, '0);
        chk("clr_sign", W'(sign), W'(0));
        @(negedge clk);
        clr      = 1'b0;
        spurious = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) spurious++;
        end
        chk("clr_no_done", W'(spurious), W'(0));

        // random operands against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            unique case (k % 4)
                0: v = {$urandom, $urandom};
                1: v = W'(0) - W'($urandom_range(1, 300));
                2: v = W'(1) << $urandom_range(0, 63);
                default: v = {$urandom, $urandom} << $urandom_range(0, 63);
            endcase
            model(v, em, es, eo);
            run_op(v, (k % 3 == 0) ? int'($urandom_range(1, 7)) : 0,
                   {$urandom, $urandom}, lat);
            chk($sformatf("rnd%0d_mag", k), mag, em);
            chk($sformatf("rnd%0d_sign", k), W'(sign), W'(es));
            chk($sformatf("rnd%0d_ovf", k), W'(ovf), W'(eo));
            if (k % 2 == 0) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/twos_to_signmag_seq.md
# twos_to_signmag_seq

Multi-cycle converter from two's complement to sign-magnitude, the inverse-direction companion of the datapath's combinational two's-complement negator. It accepts a signed WIDTH-bit operand and returns sign and magnitude using the same "copy up to and including the first 1, then invert" rule. The rule is applied CHUNK bits per cycle, LSB-first, so that a wide operand does not create a 64-bit ripple path. It sits ahead of the divider and multiplier sign-fixup logic, which consume unsigned magnitudes plus a sign bit.

## Interface
- WIDTH, 64, operand width; must be a multiple of CHUNK
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK
- clk  in  1  rising-edge clock
- clr  in  1  reset; asynchronous and active-high
- start  in  1  request; sampled only in IDLE or DONE
- in  in  WIDTH  two's-complement operand; sampled together with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; mag, sign and ovf are valid from this cycle on
- mag  out  WIDTH  magnitude |in|; held until the next accepted start
- sign  out  1  in[WIDTH-1] of the captured operand
- ovf  out  1  high when the captured operand was the most negative value (1 followed by WIDTH-1 zeros)

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture in into the working register, latch sign, clear the flip flag and chunk counter, go to RUN.
- RUN, each cycle: process chunk[cnt] of the working register.
  - sign=0: chunk passes through unchanged.
  - sign=1: bits below and including the first 1 (with flip still clear) are copied; every bit after the flip flag sets is inverted.
  - flip_out of chunk cnt feeds flip_in of chunk cnt+1.
  - The result is written back in place; cnt increments.
- RUN, cnt=N-1: write the last chunk, go to DONE, assert done.
- DONE: outputs valid.
  - start=1: accepted exactly as in IDLE (back-to-back operation), and done drops.
  - start=0: go to IDLE.
- start in RUN is ignored; in is not sampled.
- ovf = sign & (result == 1 followed by WIDTH-1 zeros). mag then holds 2^(WIDTH-1), the unsigned interpretation.
- Zero input: mag=0, sign=0, ovf=0. The flip flag never sets.

## Timing
- Reset values (clr=1, takes effect immediately and asynchronously):
  - state=IDLE, busy=0, done=0, mag=0, sign=0, ovf=0, flip=0, cnt=0.
- Reset during RUN aborts the operation; no done is produced.
- Latency: with start sampled at edge E0, chunks are written at edges E1..EN. done is high for exactly one cycle, between EN and EN+1. The latency is fixed at N cycles regardless of the operand.
- busy is high from E0 to EN.
- A new start in DONE (sampled at EN+1) produces its own done N cycles later.
- mag, sign and ovf change only at capture, during RUN and on clr.
  - mag is not guaranteed meaningful while busy=1.
- No combinational path from in or start to any output.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH and CHUNK constants
  - the helper that computes the most-negative pattern for a given WIDTH
- Sub-module chunk_negate, combinational and parameterised by CHUNK:
  - inputs: chunk_in[CHUNK], flip_in, enable (=sign)
  - outputs: chunk_out[CHUNK], flip_out
  - instantiated once, muxed by cnt
- Top level contains the FSM, counter, working register and ovf detect.

## Test plan
All scenarios use WIDTH=64, CHUNK=8.
1. in=0xFFFF_FFFF_FFFF_FFFB (-5), start one cycle -> done exactly 8 cycles after the capture edge; mag=0x5, sign=1, ovf=0; busy high for 8 cycles.
2. in=0x0000_0000_0000_1234 -> mag=0x1234, sign=0, ovf=0, same latency.
3. in=0x8000_0000_0000_0000 -> mag=0x8000_0000_0000_0000, sign=1, ovf=1.
4. in=0xFFFF_0000_0000_0000, where flip first sets in chunk 6 -> mag=0x0001_0000_0000_0000, sign=1. Also in=0 -> mag=0, sign=0.
5. Pulse start with a different in during RUN -> ignored, result unchanged. Assert clr mid-RUN -> busy, done and mag drop to 0 immediately, with no later done.
6. Assert start again in the DONE cycle with in=0xFFFF_FFFF_FFFF_FFFF -> second done 8 cycles later with mag=0x1, sign=1; the first result is held until recapture.
